if_stage: RTL and testbench

Instruction-fetch stage of the 5-stage pipelined MIPS CPU. It holds the PC and drives a variable-latency instruction-memory request/ready interface. It owns the IF/ID pipeline register, whose inst/pc4 feed decode and the control unit. It consumes the control unit's nostall and pcsource, plus the decode-stage branch/jr/jump targets, and implements delayed-branch semantics (one delay slot, never flushed).

---
 rtl/if_stage_pkg.sv | 20 ++
 rtl/if_stage_npc_sel.sv | 52 +++++
 rtl/if_stage.sv | 146 ++++++++++++++
 tb/tb_if_stage.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   - pcsource encodings (also used by the control unit)
//   - fetch FSM state encodings
//   - bubble instruction constant (sll $0,$0,0)
package if_stage_pkg;

  localparam logic [1:0] PC_SEQ = 2'b00;
  localparam logic [1:0] PC_BR  = 2'b01;
  localparam logic [1:0] PC_JR  = 2'b10;
  localparam logic [1:0] PC_J   = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FETCH = 2'b01,
    HOLD  = 2'b10
  } fetch_state_e;

  localparam logic [31:0] NOP_INST_C = 32'h0000_0000;

endpackage

// File: rtl/if_stage_npc_sel.sv
// Next-PC selection for the fetch stage (purely combinational).
// Ports:
//   pc          current fetch PC
//   pcsource    control-unit target select (seq/branch/jr/j)
//   redirect    a control transfer is being taken this cycle
//   redir_pend  a control transfer was seen while the fetch was stalled on memory
//   redir_pc    target remembered for the pending transfer
//   bpc/rpc/jpc branch, jr and j/jal targets from decode
//   pc_plus4    pc + 4 (modulo 2^32)
//   tgt         target selected by pcsource
//   npc         PC to fetch after the current word is delivered
module npc_sel
  import if_stage_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [1:0]  pcsource,
  input  logic        redirect,
  input  logic        redir_pend,
  input  logic [31:0] redir_pc,
  input  logic [31:0] bpc,
  input  logic [31:0] rpc,
  input  logic [31:0] jpc,
  output logic [31:0] pc_plus4,
  output logic [31:0] tgt,
  output logic [31:0] npc
);

  assign pc_plus4 = pc + 32'd4;

  always_comb begin
    tgt = pc_plus4;
    case (pcsource)
      PC_BR:   tgt = bpc;
      PC_JR:   tgt = rpc;
      PC_J:    tgt = jpc;
      default: tgt = pc_plus4;
    endcase
  end

  // A live redirect wins over a remembered one; the remembered one wins over
  // sequential flow so the delay slot is followed by the target.
  always_comb begin
    if (redirect) begin
      npc = tgt;
    end else if (redir_pend) begin
      npc = redir_pc;
    end else begin
      npc = pc_plus4;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage of the 5-stage MIPS pipeline.
// Holds the PC, talks to a variable-latency instruction memory and owns the
// IF/ID register. Delayed-branch semantics: the word at pc when a redirect is
// seen is always delivered, then the target is fetched.
// Ports:
//   clock, resetn           clock and asynchronous active-low reset
//   nostall, pcsource       control-unit stall and next-PC select
//   bpc, rpc, jpc           branch / jr / j targets from decode
//   imem_req, imem_addr     fetch request and address (== pc)
//   imem_ready, imem_rdata  fetch completion and instruction word
//   pc                      current fetch PC
//   inst, pc4, ifid_valid   IF/ID register contents
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = NOP_INST_C
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        nostall,
  input  logic [1:0]  pcsource,
  input  logic [31:0] bpc,
  input  logic [31:0] rpc,
  input  logic [31:0] jpc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] inst,
  output logic [31:0] pc4,
  output logic        ifid_valid
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  inst_q, inst_d;
  logic [31:0]  pc4_q, pc4_d;
  logic         valid_q, valid_d;
  logic [31:0]  fbuf_q, fbuf_d;
  logic         redir_pend_q, redir_pend_d;
  logic [31:0]  redir_pc_q, redir_pc_d;

  logic         redirect;
  logic         load;
  logic [31:0]  load_data;
  logic [31:0]  pc_plus4;
  logic [31:0]  tgt;
  logic [31:0]  npc;

  assign redirect = nostall & (pcsource != PC_SEQ);

  npc_sel u_npc_sel (
    .pc         (pc_q),
    .pcsource   (pcsource),
    .redirect   (redirect),
    .redir_pend (redir_pend_q),
    .redir_pc   (redir_pc_q),
    .bpc        (bpc),
    .rpc        (rpc),
    .jpc        (jpc),
    .pc_plus4   (pc_plus4),
    .tgt        (tgt),
    .npc        (npc)
  );

  // A word reaches IF/ID either straight from memory or from the buffer that
  // caught it while the pipeline was stalled.
  assign load = nostall & (((state_q == FETCH) & imem_ready) | (state_q == HOLD));
  assign load_data = (state_q == HOLD) ? fbuf_q : imem_rdata;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    inst_d       = inst_q;
    pc4_d        = pc4_q;
    valid_d      = valid_q;
    fbuf_d       = fbuf_q;
    redir_pend_d = redir_pend_q;
    redir_pc_d   = redir_pc_q;

    case (state_q)
      IDLE: begin
        state_d = FETCH;
      end
      FETCH, HOLD: begin
        if (load) begin
          inst_d       = load_data;
          pc4_d        = pc_plus4;
          valid_d      = 1'b1;
          pc_d         = npc;
          redir_pend_d = 1'b0;
          state_d      = FETCH;
        end else if ((state_q == FETCH) && imem_ready) begin
          // Word arrived but decode is stalled: park it and stop requesting.
          fbuf_d  = imem_rdata;
          state_d = HOLD;
        end else if ((state_q == FETCH) && nostall) begin
          // Memory still busy: push a bubble downstream. A redirect seen now
          // must survive until the delay-slot word finally arrives.
          inst_d  = NOP_INST;
          pc4_d   = 32'h0000_0000;
          valid_d = 1'b0;
          if (redirect) begin
            redir_pend_d = 1'b1;
            redir_pc_d   = tgt;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      inst_q       <= NOP_INST;
      pc4_q        <= 32'h0000_0000;
      valid_q      <= 1'b0;
      fbuf_q       <= 32'h0000_0000;
      redir_pend_q <= 1'b0;
      redir_pc_q   <= 32'h0000_0000;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      pc4_q        <= pc4_d;
      valid_q      <= valid_d;
      fbuf_q       <= fbuf_d;
      redir_pend_q <= redir_pend_d;
      redir_pc_q   <= redir_pc_d;
    end
  end

  assign imem_req   = (state_q == FETCH);
  assign imem_addr  = pc_q;
  assign pc         = pc_q;
  assign inst       = inst_q;
  assign pc4        = pc4_q;
  assign ifid_valid = valid_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage. Instruction memory is a combinational model:
// word at address A is {16'hC0DE, A[15:0]}, optionally XORed with a corruption
// mask so a stale re-read of memory is distinguishable from the buffered word.
module tb_if_stage;

  logic        clock;
  logic        resetn;
  logic        nostall;
  logic [1:0]  pcsource;
  logic [31:0] bpc, rpc, jpc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] pc, inst, pc4;
  logic        ifid_valid;
  logic [31:0] corrupt;

  int checks = 0;
  int errors = 0;

  assign imem_rdata = {16'hC0DE, imem_addr[15:0]} ^ corrupt;

  if_stage dut (
    .clock      (clock),
    .resetn     (resetn),
    .nostall    (nostall),
    .pcsource   (pcsource),
    .bpc        (bpc),
    .rpc        (rpc),
    .jpc        (jpc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .pc         (pc),
    .inst       (inst),
    .pc4        (pc4),
    .ifid_valid (ifid_valid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0; nostall = 1'b1; pcsource = 2'b00;
    bpc = 32'h0; rpc = 32'h0; jpc = 32'h0; imem_ready = 1'b1; corrupt = 32'h0;
    #3;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got %b expected 0", imem_req); end
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL rst_pc got %h expected 00000000", pc); end
    checks++; if (inst !== 32'h0) begin errors++; $display("FAIL rst_inst got %h expected 00000000", inst); end
    checks++; if (pc4 !== 32'h0) begin errors++; $display("FAIL rst_pc4 got %h expected 00000000", pc4); end
    checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b expected 0", ifid_valid); end
    tick();
    resetn = 1'b1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL idle_req got %b expected 0", imem_req); end
    $display("reset: pc=%h inst=%h valid=%b", pc, inst, ifid_valid);
  endtask

  task automatic test_sequential();
    tick();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL seq_first req=%b addr=%h expected 1/00000000", imem_req, imem_addr); end
    tick();
    checks++; if (imem_addr !== 32'h4) begin errors++; $display("FAIL seq_addr1 got %h expected 00000004", imem_addr); end
    checks++; if (inst !== 32'hC0DE0000 || pc4 !== 32'h4 || ifid_valid !== 1'b1) begin errors++; $display("FAIL seq_ifid1 inst=%h pc4=%h v=%b expected c0de0000/00000004/1", inst, pc4, ifid_valid); end
    tick();
    checks++; if (imem_addr !== 32'h8) begin errors++; $display("FAIL seq_addr2 got %h expected 00000008", imem_addr); end
    checks++; if (inst !== 32'hC0DE0004 || pc4 !== 32'h8) begin errors++; $display("FAIL seq_ifid2 inst=%h pc4=%h expected c0de0004/00000008", inst, pc4); end
    tick();
    checks++; if (imem_addr !== 32'hC || pc4 !== 32'hC) begin errors++; $display("FAIL seq_addr3 addr=%h pc4=%h expected 0000000c/0000000c", imem_addr, pc4); end
    $display("sequential: addr=%h inst=%h pc4=%h", imem_addr, inst, pc4);
  endtask

  task automatic test_branch();
    for (int i = 0; i < 20 && pc !== 32'h20; i++) tick();
    checks++; if (pc !== 32'h20) begin errors++; $display("FAIL br_reach got %h expected 00000020", pc); end
    pcsource = 2'b01; bpc = 32'h100;
    tick();
    pcsource = 2'b00;
    checks++; if (inst !== 32'hC0DE0020 || pc4 !== 32'h24) begin errors++; $display("FAIL br_slot inst=%h pc4=%h expected c0de0020/00000024", inst, pc4); end
    checks++; if (imem_addr !== 32'h100) begin errors++; $display("FAIL br_target got %h expected 00000100", imem_addr); end
    tick();
    checks++; if (inst !== 32'hC0DE0100 || pc4 !== 32'h104) begin errors++; $display("FAIL br_tgt_inst inst=%h pc4=%h expected c0de0100/00000104", inst, pc4); end
    $display("branch: addr=%h inst=%h pc4=%h", imem_addr, inst, pc4);
  endtask

  task automatic test_branch_wait();
    // Jump back to 0x20 so the same redirect can be replayed with a slow memory.
    pcsource = 2'b11; jpc = 32'h20;
    tick();
    pcsource = 2'b01; bpc = 32'h100; imem_ready = 1'b0;
    tick();
    pcsource = 2'b00;
    checks++; if (ifid_valid !== 1'b0 || inst !== 32'h0 || pc4 !== 32'h0) begin errors++; $display("FAIL bw_bubble v=%b inst=%h pc4=%h expected 0/00000000/00000000", ifid_valid, inst, pc4); end
    checks++; if (imem_addr !== 32'h20) begin errors++; $display("FAIL bw_hold_pc got %h expected 00000020", imem_addr); end
    tick();
    tick();
    checks++; if (ifid_valid !== 1'b0 || imem_addr !== 32'h20) begin errors++; $display("FAIL bw_bubble3 v=%b addr=%h expected 0/00000020", ifid_valid, imem_addr); end
    imem_ready = 1'b1;
    tick();
    checks++; if (inst !== 32'hC0DE0020 || pc4 !== 32'h24 || ifid_valid !== 1'b1) begin errors++; $display("FAIL bw_slot inst=%h pc4=%h v=%b expected c0de0020/00000024/1", inst, pc4, ifid_valid); end
    checks++; if (imem_addr !== 32'h100) begin errors++; $display("FAIL bw_target got %h expected 00000100", imem_addr); end
    tick();
    checks++; if (inst !== 32'hC0DE0100) begin errors++; $display("FAIL bw_tgt_inst got %h expected c0de0100", inst); end
    $display("branch_wait: addr=%h inst=%h", imem_addr, inst);
  endtask

  task automatic test_hold();
    pcsource = 2'b11; jpc = 32'h40;
    tick();
    pcsource = 2'b00;
    checks++; if (imem_addr !== 32'h40) begin errors++; $display("FAIL hold_reach got %h expected 00000040", imem_addr); end
    nostall = 1'b0;
    tick();
    checks++; if (imem_req !== 1'b0 || pc !== 32'h40) begin errors++; $display("FAIL hold_enter req=%b pc=%h expected 0/00000040", imem_req, pc); end
    checks++; if (inst !== 32'hC0DE0104 || pc4 !== 32'h108) begin errors++; $display("FAIL hold_ifid inst=%h pc4=%h expected c0de0104/00000108", inst, pc4); end
    // Stalled inputs must be ignored and memory no longer consulted.
    pcsource = 2'b01; bpc = 32'h999; imem_ready = 1'b0; corrupt = 32'hFFFF_0000;
    tick();
    checks++; if (imem_req !== 1'b0 || pc !== 32'h40 || inst !== 32'hC0DE0104) begin errors++; $display("FAIL hold_stay req=%b pc=%h inst=%h expected 0/00000040/c0de0104", imem_req, pc, inst); end
    nostall = 1'b1; pcsource = 2'b00;
    tick();
    checks++; if (inst !== 32'hC0DE0040 || pc4 !== 32'h44 || ifid_valid !== 1'b1) begin errors++; $display("FAIL hold_release inst=%h pc4=%h v=%b expected c0de0040/00000044/1", inst, pc4, ifid_valid); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h44) begin errors++; $display("FAIL hold_next req=%b addr=%h expected 1/00000044", imem_req, imem_addr); end
    corrupt = 32'h0; imem_ready = 1'b1;
    $display("hold: inst=%h pc4=%h addr=%h", inst, pc4, imem_addr);
  endtask

  task automatic test_jr_j();
    pcsource = 2'b10; rpc = 32'h200;
    tick();
    pcsource = 2'b00;
    checks++; if (inst !== 32'hC0DE0044 || pc4 !== 32'h48 || imem_addr !== 32'h200) begin errors++; $display("FAIL jr_slot inst=%h pc4=%h addr=%h expected c0de0044/00000048/00000200", inst, pc4, imem_addr); end
    tick();
    checks++; if (inst !== 32'hC0DE0200 || pc4 !== 32'h204) begin errors++; $display("FAIL jr_tgt inst=%h pc4=%h expected c0de0200/00000204", inst, pc4); end
    pcsource = 2'b11; jpc = 32'h3000;
    tick();
    pcsource = 2'b00;
    checks++; if (inst !== 32'hC0DE0204 || pc4 !== 32'h208 || imem_addr !== 32'h3000) begin errors++; $display("FAIL j_slot inst=%h pc4=%h addr=%h expected c0de0204/00000208/00003000", inst, pc4, imem_addr); end
    tick();
    checks++; if (inst !== 32'hC0DE3000 || pc4 !== 32'h3004) begin errors++; $display("FAIL j_tgt inst=%h pc4=%h expected c0de3000/00003004", inst, pc4); end
    $display("jr_j: inst=%h pc4=%h", inst, pc4);
  endtask

  task automatic test_wrap();
    pcsource = 2'b11; jpc = 32'hFFFF_FFFC;
    tick();
    pcsource = 2'b00;
    checks++; if (imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_reach got %h expected fffffffc", imem_addr); end
    tick();
    checks++; if (inst !== 32'hC0DEFFFC || pc4 !== 32'h0 || imem_addr !== 32'h0) begin errors++; $display("FAIL wrap inst=%h pc4=%h addr=%h expected c0defffc/00000000/00000000", inst, pc4, imem_addr); end
    $display("wrap: inst=%h pc4=%h addr=%h", inst, pc4, imem_addr);
  endtask

  task automatic test_reset_mid_hold();
    pcsource = 2'b11; jpc = 32'h500;
    tick();
    pcsource = 2'b00; nostall = 1'b0;
    tick();
    checks++; if (imem_req !== 1'b0 || pc !== 32'h500) begin errors++; $display("FAIL rh_enter req=%b pc=%h expected 0/00000500", imem_req, pc); end
    #2 resetn = 1'b0;
    #1;
    checks++; if (pc !== 32'h0 || inst !== 32'h0 || pc4 !== 32'h0 || ifid_valid !== 1'b0 || imem_req !== 1'b0) begin errors++; $display("FAIL rh_async pc=%h inst=%h pc4=%h v=%b req=%b expected all zero", pc, inst, pc4, ifid_valid, imem_req); end
    nostall = 1'b1;
    tick();
    resetn = 1'b1;
    checks++; if (imem_req !== 1'b0 || imem_addr !== 32'h0) begin errors++; $display("FAIL rh_idle req=%b addr=%h expected 0/00000000", imem_req, imem_addr); end
    tick();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL rh_first req=%b addr=%h expected 1/00000000", imem_req, imem_addr); end
    tick();
    checks++; if (inst !== 32'hC0DE0000 || pc4 !== 32'h4) begin errors++; $display("FAIL rh_deliver inst=%h pc4=%h expected c0de0000/00000004", inst, pc4); end
    $display("reset_mid_hold: addr=%h inst=%h", imem_addr, inst);
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_branch_wait();
    test_hold();
    test_jr_j();
    test_wrap();
    test_reset_mid_hold();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
